// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined WISC ALU with valid/ready backpressure,
// flush, and an architectural {Z,V,N} flag register with selective update.
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_flags,
   output logic [2:0]       flag_reg
);

   localparam int SHW = $clog2(WIDTH);
   localparam int NL  = WIDTH / LANE;
   localparam int MSB = WIDTH - 1;
   localparam int HW  = WIDTH / 2;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
   localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};
   localparam logic [SHW:0]     WL   = (SHW+1)'(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_ROR  = 4'b0110;
   localparam logic [3:0] OP_PADD = 4'b0111;
   localparam logic [3:0] OP_LLB  = 4'b1000;
   localparam logic [3:0] OP_LHB  = 4'b1001;
   localparam logic [3:0] OP_ADDR = 4'b1010;

   // S1: operand capture
   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;

   // S2: result, flags and how they commit to flag_reg
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [2:0]       flags_q, flags_d;
   logic             wr_all_q, wr_all_d;
   logic             wr_z_q, wr_z_d;
   logic [2:0]       flag_reg_q, flag_reg_d;

   logic s2_adv, s1_adv, out_hs;

   logic [WIDTH-1:0] sum, dif, sat, rot;
   logic [WIDTH-1:0] padd_res;
   logic [WIDTH-1:0] ex_res;
   logic [2:0]       ex_flags;
   logic             add_ovf, sub_ovf;
   logic             ex_v, ex_wr_all, ex_wr_z;
   logic [SHW-1:0]   sh;
   logic [SHW:0]     rsh;

   // PADDSB lanes: each lane saturates on its own, no carry across lanes
   for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      logic [LANE-1:0] la, lb, ls;
      logic            lovf;
      assign la   = s1_a_q[gi*LANE +: LANE];
      assign lb   = s1_b_q[gi*LANE +: LANE];
      assign ls   = la + lb;
      assign lovf = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);
      assign padd_res[gi*LANE +: LANE] =
         lovf ? (la[LANE-1] ? LMIN : LMAX) : ls;
   end

   // Handshake: a stage advances when its downstream can take the op
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = s1_adv && !flush;
      out_hs   = s2_valid_q && out_ready && !flush;
   end

   // Execute: combinational ALU on the S1 operands
   always_comb begin
      sh      = s1_b_q[SHW-1:0];
      rsh     = WL - {1'b0, sh};
      sum     = s1_a_q + s1_b_q;
      dif     = s1_a_q - s1_b_q;
      rot     = (s1_a_q >> sh) | (s1_a_q << rsh);
      add_ovf = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      sub_ovf = (s1_a_q[MSB] != s1_b_q[MSB]) && (dif[MSB] != s1_a_q[MSB]);
      sat     = s1_a_q[MSB] ? SMIN : SMAX;
      ex_res    = '0;
      ex_v      = 1'b0;
      ex_wr_all = 1'b0;
      ex_wr_z   = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            ex_res    = add_ovf ? sat : sum;
            ex_v      = add_ovf;
            ex_wr_all = 1'b1;
         end
         OP_SUB: begin
            ex_res    = sub_ovf ? sat : dif;
            ex_v      = sub_ovf;
            ex_wr_all = 1'b1;
         end
         OP_XOR: begin
            ex_res  = s1_a_q ^ s1_b_q;
            ex_wr_z = 1'b1;
         end
         OP_SLL: begin
            ex_res  = s1_a_q << sh;
            ex_wr_z = 1'b1;
         end
         OP_SRA: begin
            ex_res  = $unsigned($signed(s1_a_q) >>> sh);
            ex_wr_z = 1'b1;
         end
         OP_ROR: begin
            ex_res  = rot;
            ex_wr_z = 1'b1;
         end
         OP_PADD: begin
            ex_res  = padd_res;
            ex_wr_z = 1'b1;
         end
         OP_LLB: ex_res = {s1_a_q[WIDTH-1:HW], s1_b_q[HW-1:0]};
         OP_LHB: ex_res = {s1_b_q[HW-1:0], s1_a_q[HW-1:0]};
         OP_ADDR: ex_res = {s1_a_q[WIDTH-1:1], 1'b0}
                         + {s1_b_q[WIDTH-2:0], 1'b0};
         default: ex_res = '0;
      endcase
      if (ex_wr_all || ex_wr_z)
         ex_flags = {ex_res == '0, ex_v, ex_res[MSB]};
      else
         ex_flags = 3'b000;
   end

   // Next state: flush squashes both stages and blocks the flag commit
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      res_d      = res_q;
      flags_d    = flags_q;
      wr_all_d   = wr_all_q;
      wr_z_d     = wr_z_q;
      flag_reg_d = flag_reg_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               res_d    = ex_res;
               flags_d  = ex_flags;
               wr_all_d = ex_wr_all;
               wr_z_d   = ex_wr_z;
            end
         end
         if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
               s1_op_d = op;
               s1_a_d  = a;
               s1_b_d  = b;
            end
         end
         if (out_hs) begin
            if (wr_all_q)
               flag_reg_d = flags_q;
            else if (wr_z_q)
               flag_reg_d = {flags_q[2], flag_reg_q[1:0]};
         end
      end
   end

   // State registers, cleared asynchronously on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         flags_q    <= '0;
         wr_all_q   <= 1'b0;
         wr_z_q     <= 1'b0;
         flag_reg_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         res_q      <= res_d;
         flags_q    <= flags_d;
         wr_all_q   <= wr_all_d;
         wr_z_q     <= wr_z_d;
         flag_reg_q <= flag_reg_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = res_q;
   assign out_flags  = flags_q;
   assign flag_reg   = flag_reg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, stall/flush/reset sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic        out_valid, out_ready;
   logic [3:0]  op;
   logic [15:0] a, b, out_result;
   logic [2:0]  out_flags, flag_reg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16), .LANE(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .flag_reg(flag_reg)
   );

   typedef struct {
      logic [15:0] res;
      logic [2:0]  fl;
      logic [3:0]  op;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [2:0]  fl;
      logic [2:0]  freg;
   } vec_t;

   exp_t        exp_q[$];
   logic [2:0]  mflag;
   logic        hold_v;
   logic [15:0] hold_r;
   vec_t        tbl[20];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Reference model: plain integer arithmetic on the opcode rules
   function automatic exp_t ref_op(input logic [3:0] o,
                                   input logic [15:0] x,
                                   input logic [15:0] y);
      exp_t e;
      int sx, sy, ux, uy, n, s, r, la, lb;
      bit v, fl;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ux = int'(x);
      uy = int'(y);
      n  = uy % 16;
      v  = 1'b0;
      fl = 1'b1;
      r  = 0;
      case (o)
         4'h0: begin s = sx + sy; r = clamp(s, -32768, 32767); v = (r != s); end
         4'h1: begin s = sx - sy; r = clamp(s, -32768, 32767); v = (r != s); end
         4'h2: r = ux ^ uy;
         4'h4: r = (ux << n) & 'hFFFF;
         4'h5: r = (sx >>> n) & 'hFFFF;
         4'h6: r = ((ux >> n) | (ux << (16 - n))) & 'hFFFF;
         4'h7: begin
            for (int i = 0; i < 4; i++) begin
               la = (ux >> (4 * i)) & 15;
               lb = (uy >> (4 * i)) & 15;
               if (la > 7) la -= 16;
               if (lb > 7) lb -= 16;
               r |= (clamp(la + lb, -8, 7) & 15) << (4 * i);
            end
         end
         4'h8: begin r = (ux & 'hFF00) | (uy & 'hFF); fl = 1'b0; end
         4'h9: begin r = ((uy & 'hFF) << 8) | (ux & 'hFF); fl = 1'b0; end
         4'hA: begin r = ((ux & 'hFFFE) + 2 * uy) & 'hFFFF; fl = 1'b0; end
         default: begin r = 0; fl = 1'b0; end
      endcase
      e.res = 16'(r);
      e.op  = o;
      e.fl  = fl ? {e.res == 16'h0, v, e.res[15]} : 3'b000;
      return e;
   endfunction

   function automatic logic [2:0] upd(input logic [2:0] f, input exp_t e);
      case (e.op)
         4'h0, 4'h1: return e.fl;
         4'h2, 4'h4, 4'h5, 4'h6, 4'h7: return {e.fl[2], f[1:0]};
         default: return f;
      endcase
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         4: return 16'($urandom_range(0, 20));
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic run_cycle(input logic v, input logic [3:0] o,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic rdy, input logic fl,
                            output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      op        = o;
      a         = x;
      b         = y;
      out_ready = rdy;
      flush     = fl;
      #1;
      chk("flag_reg", 32'(flag_reg), 32'(mflag));
      if (hold_v) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_result", 32'(out_result), 32'(hold_r));
      end
      if (fl) chk("flush_in_ready", 32'(in_ready), 32'd0);
      acc = v && in_ready;
      if (fl) begin
         exp_q.delete();
      end else if (out_valid && rdy) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("result", 32'(out_result), 32'(e.res));
            chk("out_flags", 32'(out_flags), 32'(e.fl));
            mflag = upd(mflag, e);
         end
      end
      if (acc && !fl) exp_q.push_back(ref_op(o, x, y));
      hold_v = out_valid && !rdy && !fl;
      hold_r = out_result;
   endtask

   task automatic drain();
      logic acc;
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         run_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      run_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   n;
      tbl = '{
         '{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 3'b010},
         '{4'h1, 16'h8000, 16'h0001, 16'h8000, 3'b011, 3'b011},
         '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 3'b001, 3'b001},
         '{4'h2, 16'h0F0F, 16'h0F0F, 16'h0000, 3'b100, 3'b101},
         '{4'h8, 16'h1234, 16'h5678, 16'h1278, 3'b000, 3'b101},
         '{4'h7, 16'h7777, 16'h1111, 16'h7777, 3'b000, 3'b001},
         '{4'h7, 16'h8888, 16'h8888, 16'h8888, 3'b001, 3'b001},
         '{4'h7, 16'h1234, 16'h1111, 16'h2345, 3'b000, 3'b001},
         '{4'h6, 16'h8001, 16'h0001, 16'hC000, 3'b001, 3'b001},
         '{4'h5, 16'h8000, 16'h000F, 16'hFFFF, 3'b001, 3'b001},
         '{4'h4, 16'h0001, 16'h0010, 16'h0001, 3'b000, 3'b001},
         '{4'h9, 16'h1234, 16'h00AB, 16'hAB34, 3'b000, 3'b001},
         '{4'hA, 16'h1001, 16'h0004, 16'h1008, 3'b000, 3'b001},
         '{4'h3, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b000, 3'b001},
         '{4'h0, 16'h0001, 16'hFFFF, 16'h0000, 3'b100, 3'b100},
         '{4'h4, 16'h8000, 16'h0001, 16'h0000, 3'b100, 3'b100},
         '{4'h0, 16'h8000, 16'h8000, 16'h8000, 3'b011, 3'b011},
         '{4'h6, 16'h1234, 16'h0004, 16'h4123, 3'b000, 3'b011},
         '{4'h5, 16'h4000, 16'h0002, 16'h1000, 3'b000, 3'b011},
         '{4'hF, 16'h1234, 16'h5678, 16'h0000, 3'b000, 3'b011}
      };

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 4'h0; a = 16'h0; b = 16'h0;
      mflag = 3'b000; hold_v = 1'b0; hold_r = 16'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      chk("rst_flag_reg", 32'(flag_reg), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, one op at a time, out_ready held high
      foreach (tbl[i]) begin
         @(negedge clk);
         in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
         #1;
         chk("tbl_in_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk("tbl_lat1_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
         #1;
         n = 0;
         while (!out_valid && n < 8) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk("tbl_latency", 32'(n), 32'd0);
         chk("tbl_result", 32'(out_result), 32'(tbl[i].res));
         chk("tbl_out_flags", 32'(out_flags), 32'(tbl[i].fl));
         @(negedge clk);
         #1;
         chk("tbl_flag_reg", 32'(flag_reg), 32'(tbl[i].freg));
      end
      mflag = tbl[19].freg;

      // Back-to-back A,B,C under a 5-cycle stall
      run_cycle(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
      chk("t5_acc_a", 32'(acc), 32'd1);
      run_cycle(1'b1, 4'h1, 16'h0000, 16'h0001, 1'b0, 1'b0, acc);
      chk("t5_acc_b", 32'(acc), 32'd1);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 4'h2, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, acc);
         chk("t5_c_blocked", 32'(acc), 32'd0);
      end
      n = 0;
      acc = 1'b0;
      while (!acc && n < 10) begin
         run_cycle(1'b1, 4'h2, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0, acc);
         n++;
      end
      chk("t5_c_accepted", 32'(acc), 32'd1);
      drain();
      chk("t5_flag_final", 32'(flag_reg), 32'h5);

      // Flush with two ops in flight and an output handshake pending
      run_cycle(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
      run_cycle(1'b1, 4'h1, 16'h8000, 16'h0001, 1'b0, 1'b0, acc);
      run_cycle(1'b1, 4'h2, 16'h1111, 16'h2222, 1'b1, 1'b1, acc);
      chk("t6_flush_acc", 32'(acc), 32'd0);
      run_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
      chk("t6_flush_valid", 32'(out_valid), 32'd0);
      chk("t6_flush_flag", 32'(flag_reg), 32'h5);

      // Reset asserted in the middle of a stall
      run_cycle(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
      run_cycle(1'b1, 4'h1, 16'h0000, 16'h0001, 1'b0, 1'b0, acc);
      run_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_result", 32'(out_result), 32'd0);
      chk("t6_rst_flags", 32'(out_flags), 32'd0);
      chk("t6_rst_flag_reg", 32'(flag_reg), 32'd0);
      exp_q.delete();
      mflag = 3'b000;
      hold_v = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
      chk("t6_rst_valid2", 32'(out_valid), 32'd0);

      // Randomized traffic with stalls and occasional flushes
      for (int i = 0; i < 800; i++) begin
         run_cycle($urandom_range(0, 3) != 0, 4'($urandom), pick(), pick(),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                   acc);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
